// File: rtl/line_rr_arbiter_pkg.sv
// Shared types for the two-way cacheline arbiter: FSM states, requester
// identities and the latched line request.
package arb_pkg;

  localparam int ARB_LINE_W = 256;
  localparam int ARB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Bit position in the request vector doubles as the enum value.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_LINE_W-1:0] wdata;
    logic                  write;
  } line_req_t;

endpackage

// File: rtl/line_rr_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. On a tie the requester that
// was not granted last time wins; a lone requester always wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  requester_t last,
  output requester_t grant,
  output logic       valid
);

  // Pick a winner from the pending set and the previous grant.
  always_comb begin
    valid = |req;
    grant = REQ_I;
    if (req == 2'b11) begin
      grant = (last == REQ_I) ? REQ_D : REQ_I;
    end else if (req[1]) begin
      grant = REQ_D;
    end
  end

endmodule

// File: rtl/line_rr_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache for the shared
// cacheline adaptor. The winning request is latched on grant, so requester
// inputs are ignored until the adaptor responds. Valid/ready contract: a
// requester holds read/write high until its resp pulse; the adaptor holds
// its command from req_q until arb_mem_resp, which is a one-cycle pulse.
module line_rr_arbiter
  import arb_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_icache_read,
  input  logic              arb_icache_write,
  input  logic [ADDR_W-1:0] arb_icache_address,
  input  logic [LINE_W-1:0] arb_icache_wdata,
  output logic              arb_icache_resp,
  output logic [LINE_W-1:0] arb_icache_rdata,
  input  logic              arb_dcache_read,
  input  logic              arb_dcache_write,
  input  logic [ADDR_W-1:0] arb_dcache_address,
  input  logic [LINE_W-1:0] arb_dcache_wdata,
  output logic              arb_dcache_resp,
  output logic [LINE_W-1:0] arb_dcache_rdata,
  output logic              arb_mem_read,
  output logic              arb_mem_write,
  output logic [ADDR_W-1:0] arb_mem_address,
  output logic [LINE_W-1:0] arb_mem_wdata,
  input  logic              arb_mem_resp,
  input  logic [LINE_W-1:0] arb_mem_rdata
);

  arb_state_t state_q, state_d;
  requester_t last_grant_q;
  requester_t pick_grant;
  logic       pick_valid;
  line_req_t  req_q;
  line_req_t  i_req, d_req;
  logic       i_pending, d_pending;

  // Pack each requester's inputs; write takes precedence over read.
  always_comb begin
    i_pending   = arb_icache_read | arb_icache_write;
    d_pending   = arb_dcache_read | arb_dcache_write;
    i_req.addr  = arb_icache_address;
    i_req.wdata = arb_icache_wdata;
    i_req.write = arb_icache_write;
    d_req.addr  = arb_dcache_address;
    d_req.wdata = arb_dcache_wdata;
    d_req.write = arb_dcache_write;
  end

  rr_pick2 u_pick (
    .req   ({d_pending, i_pending}),
    .last  (last_grant_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request on grant; record the owner on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '0;
      last_grant_q <= REQ_I;
    end else begin
      if (state_q == IDLE && pick_valid) begin
        req_q <= (pick_grant == REQ_D) ? d_req : i_req;
      end
      if (state_q == SERVE_I && arb_mem_resp) begin
        last_grant_q <= REQ_I;
      end else if (state_q == SERVE_D && arb_mem_resp) begin
        last_grant_q <= REQ_D;
      end
    end
  end

  // Next-state: grant from IDLE, return to IDLE on adaptor completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_grant == REQ_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (arb_mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: commands only from req_q while serving; resp gated by owner
  // and suppressed by a coincident reset.
  always_comb begin
    arb_mem_read    = 1'b0;
    arb_mem_write   = 1'b0;
    arb_mem_address = '0;
    arb_mem_wdata   = '0;
    arb_icache_resp = 1'b0;
    arb_dcache_resp = 1'b0;
    if (state_q == SERVE_I || state_q == SERVE_D) begin
      arb_mem_read    = ~req_q.write;
      arb_mem_write   = req_q.write;
      arb_mem_address = req_q.addr;
      arb_mem_wdata   = req_q.wdata;
    end
    arb_icache_resp = arb_mem_resp && !rst && (state_q == SERVE_I);
    arb_dcache_resp = arb_mem_resp && !rst && (state_q == SERVE_D);
  end

  // Read data fans out to both caches; resp alone qualifies it.
  assign arb_icache_rdata = arb_mem_rdata;
  assign arb_dcache_rdata = arb_mem_rdata;

endmodule

// File: tb/tb_line_rr_arbiter.sv
// Bench for line_rr_arbiter: directed sequence, cycle table, and a random
// run against a transaction-level reference model.
module tb_line_rr_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [LINE_W-1:0] I_WD = {8{32'h1111_2222}};
  localparam logic [LINE_W-1:0] D_WD = {8{32'hDDDD_0000}};

  logic              clk = 1'b0;
  logic              rst;
  logic              ir, iw, dr, dw;
  logic [ADDR_W-1:0] ia, da;
  logic [LINE_W-1:0] iwd, dwd;
  logic              i_resp, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mresp;
  logic [LINE_W-1:0] mrdata;

  int errors = 0;
  int checks = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  line_rr_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .arb_icache_read    (ir),
    .arb_icache_write   (iw),
    .arb_icache_address (ia),
    .arb_icache_wdata   (iwd),
    .arb_icache_resp    (i_resp),
    .arb_icache_rdata   (i_rdata),
    .arb_dcache_read    (dr),
    .arb_dcache_write   (dw),
    .arb_dcache_address (da),
    .arb_dcache_wdata   (dwd),
    .arb_dcache_resp    (d_resp),
    .arb_dcache_rdata   (d_rdata),
    .arb_mem_read       (mem_read),
    .arb_mem_write      (mem_write),
    .arb_mem_address    (mem_addr),
    .arb_mem_wdata      (mem_wdata),
    .arb_mem_resp       (mresp),
    .arb_mem_rdata      (mrdata)
  );

  typedef struct {
    logic              ir, iw;
    logic [ADDR_W-1:0] ia;
    logic              dr, dw;
    logic [ADDR_W-1:0] da;
    logic              mresp, rst;
    logic              e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [1:0]        e_wsel;  // 0: zero, 1: I line, 2: D line
    logic              e_ir, e_dr;
  } vec_t;

  vec_t tbl[$];

  // Scoreboard compare
  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] x;
    for (int k = 0; k < LINE_W / 32; k++) x[k*32 +: 32] = $urandom();
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ir = 0; iw = 0; ia = '0; iwd = I_WD;
    dr = 0; dw = 0; da = '0; dwd = D_WD;
    mresp = 0; mrdata = '0;
  endtask

  task automatic add(input logic r_ir, r_iw, input logic [31:0] r_ia,
                     input logic r_dr, r_dw, input logic [31:0] r_da,
                     input logic r_mresp, r_rst,
                     input logic x_rd, x_wr, input logic [31:0] x_addr,
                     input logic [1:0] x_wsel, input logic x_ir, x_dr);
    vec_t v;
    v.ir = r_ir; v.iw = r_iw; v.ia = r_ia;
    v.dr = r_dr; v.dw = r_dw; v.da = r_da;
    v.mresp = r_mresp; v.rst = r_rst;
    v.e_rd = x_rd; v.e_wr = x_wr; v.e_addr = x_addr;
    v.e_wsel = x_wsel; v.e_ir = x_ir; v.e_dr = x_dr;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Reference model: one outstanding transaction, round-robin on ties.
  bit                m_busy;
  int                m_owner;  // 0 = I, 1 = D
  int                m_last;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  bit                m_write;

  task automatic model_edge();
    bit pi, pd;
    int w;
    if (rst) begin
      m_busy = 0; m_last = 0; m_addr = '0; m_wdata = '0; m_write = 0;
    end else if (m_busy) begin
      if (mresp) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end else begin
      pi = ir || iw;
      pd = dr || dw;
      if (pi || pd) begin
        if (pi && pd) w = 1 - m_last;
        else w = pd ? 1 : 0;
        m_busy  = 1;
        m_owner = w;
        m_addr  = w ? da : ia;
        m_wdata = w ? dwd : iwd;
        m_write = w ? dw : iw;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    string p;
    p = $sformatf("rand%0d", cyc);
    check({p, " mem_read"},  LINE_W'(mem_read),  LINE_W'(m_busy && !m_write));
    check({p, " mem_write"}, LINE_W'(mem_write), LINE_W'(m_busy && m_write));
    check({p, " mem_addr"},  LINE_W'(mem_addr),  m_busy ? LINE_W'(m_addr) : '0);
    check({p, " mem_wdata"}, mem_wdata,          m_busy ? m_wdata : '0);
    check({p, " i_resp"}, LINE_W'(i_resp),
          LINE_W'(m_busy && m_owner == 0 && mresp && !rst));
    check({p, " d_resp"}, LINE_W'(d_resp),
          LINE_W'(m_busy && m_owner == 1 && mresp && !rst));
    check({p, " i_rdata"}, i_rdata, mrdata);
    check({p, " d_rdata"}, d_rdata, mrdata);
  endtask

  initial begin
    logic [LINE_W-1:0] exp_wd;
    clear_inputs();
    rst = 1;

    // Reset values
    tick();
    @(negedge clk);
    check("reset mem_read",  LINE_W'(mem_read),  '0);
    check("reset mem_write", LINE_W'(mem_write), '0);
    check("reset mem_addr",  LINE_W'(mem_addr),  '0);
    check("reset mem_wdata", mem_wdata,          '0);
    check("reset i_resp",    LINE_W'(i_resp),    '0);
    check("reset d_resp",    LINE_W'(d_resp),    '0);
    tick();
    rst = 0;

    // Lone I read at 0x60, adaptor answers in the 8th serving cycle
    ir = 1; ia = 32'h60;
    @(negedge clk);
    check("seq1 idle mem_read", LINE_W'(mem_read), '0);
    tick();
    ir = 0; ia = 32'hFFC0;
    @(negedge clk);
    check("seq1 mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
    check("seq1 mem_addr", LINE_W'(mem_addr), LINE_W'(32'h60));
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("seq1 hold%0d mem_read", c), LINE_W'(mem_read), LINE_W'(1'b1));
      check($sformatf("seq1 hold%0d i_resp", c), LINE_W'(i_resp), '0);
    end
    tick();
    mresp = 1; mrdata = rand_line();
    @(negedge clk);
    check("seq1 i_resp", LINE_W'(i_resp), LINE_W'(1'b1));
    check("seq1 d_resp", LINE_W'(d_resp), '0);
    check("seq1 i_rdata", i_rdata, mrdata);
    check("seq1 d_rdata", d_rdata, mrdata);
    tick();
    mresp = 0;
    @(negedge clk);
    check("seq1 after mem_read", LINE_W'(mem_read), '0);
    check("seq1 after i_resp", LINE_W'(i_resp), '0);

    // Cycle table: tie/alternation, sticky request, read+write, reset abort
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  0,0,32'h0,    0,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  0,1,32'h1000, 2,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 1,0,  0,1,32'h1000, 2,0,1);
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  0,0,32'h0,    0,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  1,0,32'h60,   1,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 1,0,  1,0,32'h60,   1,1,0);
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  0,0,32'h0,    0,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 1,0,  0,1,32'h1000, 2,0,1);
    add(1,0,32'h60, 0,1,32'h1000, 0,0,  0,0,32'h0,    0,0,0);
    add(1,0,32'h60, 0,1,32'h1000, 1,0,  1,0,32'h60,   1,1,0);
    add(0,0,32'h0,  0,0,32'h0,    1,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  0,0,32'h0,    0,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  1,1,32'h80,   0,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  0,0,32'hC0,   0,0,  0,1,32'h80,   2,0,0);
    add(0,0,32'h0,  1,0,32'hC0,   0,0,  0,1,32'h80,   2,0,0);
    add(0,0,32'h0,  0,0,32'hC0,   1,0,  0,1,32'h80,   2,0,1);
    add(0,0,32'h0,  0,0,32'h0,    0,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  1,0,32'h40,   0,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  1,0,32'h40,   0,0,  1,0,32'h40,   2,0,0);
    add(0,0,32'h0,  1,0,32'h40,   0,0,  1,0,32'h40,   2,0,0);
    add(0,0,32'h0,  0,0,32'h40,   1,1,  1,0,32'h40,   2,0,0);
    add(0,0,32'h0,  0,0,32'h0,    1,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  0,0,32'h0,    0,0,  0,0,32'h0,    0,0,0);
    add(1,0,32'h60, 1,0,32'h40,   0,0,  0,0,32'h0,    0,0,0);
    add(0,0,32'h0,  0,0,32'h0,    1,0,  1,0,32'h40,   2,0,1);
    add(0,0,32'h0,  0,0,32'h0,    0,0,  0,0,32'h0,    0,0,0);

    do_reset();
    foreach (tbl[i]) begin
      ir = tbl[i].ir; iw = tbl[i].iw; ia = tbl[i].ia;
      dr = tbl[i].dr; dw = tbl[i].dw; da = tbl[i].da;
      mresp = tbl[i].mresp; rst = tbl[i].rst;
      mrdata = rand_line();
      @(negedge clk);
      exp_wd = (tbl[i].e_wsel == 2'd1) ? I_WD : (tbl[i].e_wsel == 2'd2) ? D_WD : '0;
      check($sformatf("row%0d mem_read", i),  LINE_W'(mem_read),  LINE_W'(tbl[i].e_rd));
      check($sformatf("row%0d mem_write", i), LINE_W'(mem_write), LINE_W'(tbl[i].e_wr));
      check($sformatf("row%0d mem_addr", i),  LINE_W'(mem_addr),  LINE_W'(tbl[i].e_addr));
      check($sformatf("row%0d mem_wdata", i), mem_wdata,          exp_wd);
      check($sformatf("row%0d i_resp", i),    LINE_W'(i_resp),    LINE_W'(tbl[i].e_ir));
      check($sformatf("row%0d d_resp", i),    LINE_W'(d_resp),    LINE_W'(tbl[i].e_dr));
      check($sformatf("row%0d i_rdata", i),   i_rdata,            mrdata);
      tick();
    end
    rst = 0;

    // Random run against the reference model
    do_reset();
    m_busy = 0; m_last = 0; m_owner = 0; m_addr = '0; m_wdata = '0; m_write = 0;
    for (int c = 0; c < 3000; c++) begin
      ir    = ($urandom_range(0, 2) == 0);
      iw    = ($urandom_range(0, 9) == 0);
      ia    = {$urandom(), 5'b0} >> 5 << 5;
      iwd   = rand_line();
      dr    = ($urandom_range(0, 2) == 0);
      dw    = ($urandom_range(0, 3) == 0);
      da    = $urandom() & 32'hFFFF_FFE0;
      dwd   = rand_line();
      mresp = ($urandom_range(0, 3) == 0);
      mrdata = rand_line();
      rst   = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_edge();
      #1;
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
